// File: rtl/rr_arbiter_n_if.sv
// Request/grant bundle between N requesters and the round-robin arbiter.
// The master drives the requests and slot gating; the slave returns the grant.
interface rr_arbiter_n_if #(
   parameter int unsigned N    = 3,
   parameter int unsigned IDXW = (N > 2) ? $clog2(N) : 1
);
   logic            en;
   logic            output_empty;
   logic [N-1:0]    req;
   logic [N-1:0]    last;
   logic [N-1:0]    win;
   logic            win_valid;
   logic [IDXW-1:0] win_idx;
   logic            locked;

   modport master (
      output en, output_empty, req, last,
      input  win, win_valid, win_idx, locked
   );

   modport slave (
      input  en, output_empty, req, last,
      output win, win_valid, win_idx, locked
   );
endinterface

// File: rtl/rr_arbiter_n.sv
// N-way round-robin arbiter with a zero-latency grant and an optional
// multi-flit packet lock that holds the grant until the tail flit.
module rr_arbiter_n #(
   parameter int unsigned N             = 3,
   parameter int unsigned INIT_PRIORITY = 0,
   parameter bit          LOCK_EN       = 1'b1
) (
   input logic          clk,
   input logic          reset_n,
   rr_arbiter_n_if.slave bus
);
   localparam int unsigned     IDXW     = (N > 2) ? $clog2(N) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);
   localparam logic [IDXW-1:0] INIT_IDX = IDXW'(INIT_PRIORITY);

   generate
      if (N < 2 || N > 16) begin : g_bad_n
         $error("rr_arbiter_n: N must be in 2..16");
      end
      if (INIT_PRIORITY >= N) begin : g_bad_init
         $error("rr_arbiter_n: INIT_PRIORITY must be in 0..N-1");
      end
   endgenerate

   logic [IDXW-1:0] ptr_q, ptr_d;
   logic [IDXW-1:0] lock_idx_q, lock_idx_d;
   logic            locked_q, locked_d;

   logic            gnt_opp_c;
   logic            scan_hit_c;
   logic [IDXW-1:0] scan_idx_c;
   logic [N-1:0]    win_c;
   logic            win_valid_c;
   logic [IDXW-1:0] win_idx_c;

   function automatic logic [IDXW-1:0] idx_inc(input logic [IDXW-1:0] i);
      return (i == LAST_IDX) ? '0 : i + IDXW'(1);
   endfunction

   // Reset also gates the grant so nothing is offered while reset_n is low.
   assign gnt_opp_c = reset_n & bus.en & bus.output_empty;

   // First requester found scanning from ptr upward with wraparound.
   always_comb begin : p_scan
      int unsigned pos;
      scan_hit_c = 1'b0;
      scan_idx_c = '0;
      pos        = 0;
      for (int unsigned k = 0; k < N; k++) begin
         pos = 32'(ptr_q) + k;
         if (pos >= N) pos = pos - N;
         if (!scan_hit_c && bus.req[IDXW'(pos)]) begin
            scan_hit_c = 1'b1;
            scan_idx_c = IDXW'(pos);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin : p_state
      if (!reset_n) begin
         ptr_q      <= INIT_IDX;
         lock_idx_q <= '0;
         locked_q   <= 1'b0;
      end else begin
         ptr_q      <= ptr_d;
         lock_idx_q <= lock_idx_d;
         locked_q   <= locked_d;
      end
   end

   // Pointer advances only past a tail flit; a non-tail grant opens a lock instead.
   always_comb begin : p_next
      ptr_d      = ptr_q;
      lock_idx_d = lock_idx_q;
      locked_d   = locked_q;
      if (win_valid_c) begin
         if (locked_q) begin
            if (bus.last[lock_idx_q]) begin
               locked_d = 1'b0;
               ptr_d    = idx_inc(lock_idx_q);
            end
         end else if (LOCK_EN && !bus.last[scan_idx_c]) begin
            locked_d   = 1'b1;
            lock_idx_d = scan_idx_c;
         end else begin
            ptr_d = idx_inc(scan_idx_c);
         end
      end
   end

   always_comb begin : p_out
      win_c = '0;
      if (gnt_opp_c) begin
         if (locked_q) begin
            win_c[lock_idx_q] = bus.req[lock_idx_q];
         end else if (scan_hit_c) begin
            win_c[scan_idx_c] = 1'b1;
         end
      end
      win_valid_c = |win_c;
      win_idx_c   = '0;
      if (win_valid_c) win_idx_c = locked_q ? lock_idx_q : scan_idx_c;
   end

   assign bus.win       = win_c;
   assign bus.win_valid = win_valid_c;
   assign bus.win_idx   = win_idx_c;
   assign bus.locked    = locked_q;

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Scoreboard bench for rr_arbiter_n: a locking N=3 instance and a
// non-locking N=2 instance with INIT_PRIORITY=1.
module tb_rr_arbiter_n;
   logic clk = 1'b0;
   logic reset_n;

   always #5 clk = ~clk;

   rr_arbiter_n_if #(.N(3)) ifa ();
   rr_arbiter_n_if #(.N(2)) ifb ();

   rr_arbiter_n #(.N(3), .INIT_PRIORITY(0), .LOCK_EN(1'b1)) dut_a (
      .clk(clk), .reset_n(reset_n), .bus(ifa.slave)
   );
   rr_arbiter_n #(.N(2), .INIT_PRIORITY(1), .LOCK_EN(1'b0)) dut_b (
      .clk(clk), .reset_n(reset_n), .bus(ifb.slave)
   );

   typedef struct {
      logic [3:0] win;
      logic       locked;
   } exp_t;

   exp_t        sb_q[$];
   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, want);
   endtask

   function automatic logic [31:0] oh_idx(input logic [3:0] v);
      logic [31:0] r;
      r = 0;
      for (int i = 3; i >= 0; i--) if (v[i]) r = 32'(i);
      return r;
   endfunction

   task automatic cmp_a(input string tag);
      exp_t x;
      x = sb_q.pop_front();
      check_eq({tag, "_win"},    32'(ifa.win),       32'(x.win));
      check_eq({tag, "_valid"},  32'(ifa.win_valid), 32'(|x.win));
      check_eq({tag, "_idx"},    32'(ifa.win_idx),   oh_idx(x.win));
      check_eq({tag, "_locked"}, 32'(ifa.locked),    32'(x.locked));
   endtask

   task automatic step_a(input string tag, input logic [2:0] r, input logic [2:0] l,
                         input logic e, input logic oe, input logic [2:0] ew, input logic el);
      ifa.req = r; ifa.last = l; ifa.en = e; ifa.output_empty = oe;
      sb_q.push_back('{4'(ew), el});
      @(negedge clk);
      cmp_a(tag);
      @(posedge clk);
      #1;
   endtask

   task automatic step_b(input string tag, input logic [1:0] r, input logic [1:0] l,
                         input logic [1:0] ew);
      exp_t x;
      ifb.req = r; ifb.last = l; ifb.en = 1'b1; ifb.output_empty = 1'b1;
      sb_q.push_back('{4'(ew), 1'b0});
      @(negedge clk);
      x = sb_q.pop_front();
      check_eq({tag, "_win"},    32'(ifb.win),     32'(x.win));
      check_eq({tag, "_idx"},    32'(ifb.win_idx), oh_idx(x.win));
      check_eq({tag, "_locked"}, 32'(ifb.locked),  32'(x.locked));
      @(posedge clk);
      #1;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   logic [2:0] rr_seq [5];

   initial begin
      rr_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
      reset_n = 1'b1;
      ifa.en = 1'b1; ifa.output_empty = 1'b1; ifa.req = 3'b111; ifa.last = 3'b111;
      ifb.en = 1'b1; ifb.output_empty = 1'b1; ifb.req = 2'b00;  ifb.last = 2'b00;

      // Reset with requests pending: nothing granted.
      #1 reset_n = 1'b0;
      #2;
      sb_q.push_back('{4'b0000, 1'b0});
      cmp_a("rst");
      @(posedge clk);
      @(posedge clk);
      #1 reset_n = 1'b1;

      // Plain rotation with every flit a tail.
      for (int i = 0; i < 5; i++)
         step_a($sformatf("rr%0d", i), 3'b111, 3'b111, 1'b1, 1'b1, rr_seq[i], 1'b0);

      // Slot gating holds the pointer (next is 2).
      step_a("gate_en0a", 3'b111, 3'b111, 1'b0, 1'b1, 3'b000, 1'b0);
      step_a("gate_en0b", 3'b111, 3'b111, 1'b0, 1'b1, 3'b000, 1'b0);
      step_a("gate_full", 3'b111, 3'b111, 1'b1, 1'b0, 3'b000, 1'b0);
      step_a("gate_go",   3'b111, 3'b111, 1'b1, 1'b1, 3'b100, 1'b0);

      // Four-flit packet on requester 0.
      step_a("pkt_g1",  3'b111, 3'b110, 1'b1, 1'b1, 3'b001, 1'b0);
      step_a("pkt_g2",  3'b111, 3'b110, 1'b1, 1'b1, 3'b001, 1'b1);
      step_a("pkt_g3",  3'b111, 3'b110, 1'b1, 1'b1, 3'b001, 1'b1);
      step_a("pkt_g4",  3'b111, 3'b111, 1'b1, 1'b1, 3'b001, 1'b1);
      step_a("pkt_aft", 3'b111, 3'b111, 1'b1, 1'b1, 3'b010, 1'b0);

      // Lock on 0 survives its requester going idle.
      step_a("lk_start", 3'b001, 3'b000, 1'b1, 1'b1, 3'b001, 1'b0);
      step_a("lk_idle1", 3'b110, 3'b000, 1'b1, 1'b1, 3'b000, 1'b1);
      step_a("lk_idle2", 3'b110, 3'b000, 1'b1, 1'b1, 3'b000, 1'b1);
      step_a("lk_tail",  3'b111, 3'b001, 1'b1, 1'b1, 3'b001, 1'b1);
      step_a("lk_next",  3'b111, 3'b111, 1'b1, 1'b1, 3'b010, 1'b0);

      // Pointer wrap 2 -> 0.
      step_a("wrap_g1", 3'b010, 3'b111, 1'b1, 1'b1, 3'b010, 1'b0);
      step_a("wrap_g0", 3'b011, 3'b111, 1'b1, 1'b1, 3'b001, 1'b0);

      // Asynchronous reset in the middle of a locked packet.
      step_a("mid_g1", 3'b111, 3'b000, 1'b1, 1'b1, 3'b010, 1'b0);
      step_a("mid_g2", 3'b111, 3'b000, 1'b1, 1'b1, 3'b010, 1'b1);
      #1 reset_n = 1'b0;
      #1;
      sb_q.push_back('{4'b0000, 1'b0});
      cmp_a("mid_rst");
      ifa.req = 3'b000;
      #1 reset_n = 1'b1;
      step_a("post_rst", 3'b111, 3'b111, 1'b1, 1'b1, 3'b001, 1'b0);

      // Two-way, INIT_PRIORITY=1, lock disabled: last ignored.
      step_b("b0", 2'b11, 2'b00, 2'b10);
      step_b("b1", 2'b11, 2'b00, 2'b01);
      step_b("b2", 2'b11, 2'b00, 2'b10);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/rr_arbiter_n.md
RR_ARBITER_N -- requirements
Module: rr_arbiter_n

Interface
REQ-001 SHALL have parameter: N, 3, number of requesters; legal 2..16.
REQ-002 SHALL have parameter: INIT_PRIORITY, 0, requester index with top priority after reset; legal 0..N-1.
REQ-003 SHALL have parameter: LOCK_EN, 1, 1 = multi-flit packet lock enabled, 0 = per-cycle arbitration only.
REQ-004 SHALL derive localparam IDXW = max(1, ceil(log2(N))).
REQ-005 SHALL have port: clk  input  1  single clock, rising edge.
REQ-006 SHALL have port: reset_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port: en  input  1  this arbiter's odd/even slot is active.
REQ-008 SHALL have port: output_empty  input  1  shared output buffer can accept a flit.
REQ-009 SHALL have port: req  input  N  per-requester request.
REQ-010 SHALL have port: last  input  N  per-requester tail-flit flag, sampled only with that requester's grant.
REQ-011 SHALL have port: win  output  N  one-hot grant, combinational.
REQ-012 SHALL have port: win_valid  output  1  OR of win.
REQ-013 SHALL have port: win_idx  output  IDXW  encoded index of the granted requester, 0 when win_valid=0.
REQ-014 SHALL have port: locked  output  1  packet lock held (registered).

Function
REQ-015 SHALL keep state: ptr (priority pointer, 0..N-1), locked, lock_idx.
REQ-016 SHALL define grant opportunity G = reset_n && en && output_empty; with G=0, win=0 and no state change.
REQ-017 Unlocked and G=1: SHALL grant the first requester with req=1, scanning ptr, ptr+1, ... modulo N (wrap N-1 -> 0), in the same cycle (zero latency).
REQ-018 Unlocked and no req set: win=0 and state SHALL be unchanged.
REQ-019 Unlocked grant to index g with LOCK_EN=0 or last[g]=1: ptr SHALL be set to (g+1) mod N on the next edge.
REQ-020 Unlocked grant to g with LOCK_EN=1 and last[g]=0: next edge SHALL set locked=1 and lock_idx=g, and leave ptr unchanged.
REQ-021 Locked: SHALL grant only lock_idx, and only when G=1 and req[lock_idx]=1; all other requests SHALL receive win=0.
REQ-022 Locked with req[lock_idx]=0 or G=0: win=0; locked, lock_idx and ptr SHALL be held (no timeout).
REQ-023 Locked grant with last[lock_idx]=1: next edge SHALL set locked=0 and ptr=(lock_idx+1) mod N; next grant opportunity is then unlocked arbitration.
REQ-024 Locked grant with last[lock_idx]=0: state SHALL be unchanged.
REQ-025 With LOCK_EN=0, last SHALL be ignored and locked SHALL stay 0.
REQ-026 SHALL never assert more than one win bit; win_idx SHALL equal the one-hot position of win.
REQ-027 Illegal N or INIT_PRIORITY SHALL cause an elaboration error.

Reset
REQ-028 reset_n=0 SHALL asynchronously set ptr=INIT_PRIORITY, locked=0, lock_idx=0.
REQ-029 While reset_n=0, win=0, win_valid=0, win_idx=0, locked=0, regardless of other inputs.
REQ-030 Reset asserted mid-packet SHALL discard the lock; the first grant after release SHALL follow REQ-017 from INIT_PRIORITY.

Verification
REQ-031 N=3, INIT=0, req=111, last=111, en=empty=1 continuously -> win_idx sequence 0,1,2,0,1.
REQ-032 req=111, en=0 for 2 cycles then en=1 (same with output_empty=0) -> win=000 while gated, ptr unchanged, next grant the same index as without gating.
REQ-033 req=111, last[0]=0 for 3 grants then 1 -> win=001 on 4 consecutive cycles, locked=1 after the first through the fourth grant, fifth grant win_idx=1.
REQ-034 Locked on 0, req=110 for 2 cycles -> win=000, locked=1, lock_idx=0 held; req[0] returns with last[0]=1 -> win=001, then locked=0.
REQ-035 Wrap: grant to index 1 (ptr becomes 2), then req=011 -> win_idx=0; N=2, INIT=1, req=11 -> win_idx 1,0,1.
REQ-036 Mid-lock, reset_n pulsed low asynchronously between edges -> win=000 and locked=0 immediately; after release with req=111 -> win_idx=INIT_PRIORITY.
